// File: rtl/s2a_controller_pkg.sv
// Shared types and constants for the stream-to-AXI write-back stage.
package s2a_controller_pkg;

    localparam int unsigned BLK_BYTES = 64;
    localparam int unsigned BEAT_BITS = 4;
    localparam int unsigned BLK_SHIFT = $clog2(BLK_BYTES);
    localparam int unsigned CNT_W     = 22;
    localparam int unsigned BLK_W     = CNT_W - BEAT_BITS;
    localparam int unsigned ADDR_W    = 32;

    typedef enum logic [1:0] {
        S2A_IDLE = 2'd0,
        S2A_ADDR = 2'd1,
        S2A_DATA = 2'd2,
        S2A_RESP = 2'd3
    } s2a_state_e;

endpackage

// File: rtl/s2a_controller_toggle_sync.sv
// Multi-flop toggle synchroniser; emits a one-cycle pulse per input toggle.
module s2a_controller_toggle_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog_in,
    output logic pulse_c
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], tog_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign pulse_c = sync_q[STAGES-1] ^ hist_q;

endmodule

// File: rtl/s2a_controller.sv
// Stream-to-AXI write-back: fills a ping-pong buffer in Sclk, writes each full half as a 16-beat burst.
// Optional S2A_BRESP_CHECK_EN adds AXI_bresp and a saturating error-response counter.
module s2a_controller
    import s2a_controller_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         Sclk,
    input  logic         rst,
    input  logic         sync,
    input  logic         Ien,
    output logic [4:0]   Iaddr,
    input  logic [31:0]  ibase,
    input  logic [23:6]  isize,
    output logic [23:6]  iacnt,
    output logic [31:0]  ibcnt,
    input  logic         AXI_clk,
    input  logic         AXI_rst_n,
    output logic [31:0]  AXI_awaddr,
    output logic         AXI_awvalid,
    input  logic         AXI_awready,
    output logic         AXI_wvalid,
    input  logic         AXI_wready,
    output logic         AXI_wlast,
    input  logic         AXI_bvalid,
    output logic         AXI_bready,
    output logic [4:0]   s2a_addr,
    output logic         s2a_en,
    output logic         overrun
`ifdef S2A_BRESP_CHECK_EN
    ,
    input  logic [1:0]   AXI_bresp,
    output logic [15:0]  bresp_err_cnt
`endif
);

    localparam int unsigned BLK_ADDR_W = ADDR_W - BLK_SHIFT;

    // ---------------- Sclk domain: write counters and request toggle ----------------
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       bcnt_q;
    logic              req_tog_q;
    logic [ADDR_W-1:0] awaddr_lat_q;
    logic              last_blk;
    logic              unused_ibase;

    assign last_blk     = (cnt_q[CNT_W-1:BEAT_BITS] == BLK_W'(isize - 18'd1));
    assign unused_ibase = ^ibase[BLK_SHIFT-1:0];

    always_ff @(posedge Sclk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            bcnt_q       <= '0;
            req_tog_q    <= 1'b0;
            awaddr_lat_q <= '0;
        end else if (sync) begin
            cnt_q  <= '0;
            bcnt_q <= '0;
        end else if (Ien) begin
            if (cnt_q[BEAT_BITS-1:0] != {BEAT_BITS{1'b1}}) begin
                cnt_q[BEAT_BITS-1:0] <= cnt_q[BEAT_BITS-1:0] + BEAT_BITS'(1);
            end else begin
                // Half full: latch the block address and hand it to the AXI side
                awaddr_lat_q <= {BLK_ADDR_W'(ibase[ADDR_W-1:BLK_SHIFT]
                                             + BLK_ADDR_W'(cnt_q[CNT_W-1:BEAT_BITS])),
                                 BLK_SHIFT'(0)};
                req_tog_q            <= ~req_tog_q;
                cnt_q[BEAT_BITS-1:0] <= '0;
                if (last_blk) begin
                    cnt_q[CNT_W-1:BEAT_BITS] <= '0;
                    bcnt_q                   <= bcnt_q + 32'd1;
                end else begin
                    cnt_q[CNT_W-1:BEAT_BITS] <= cnt_q[CNT_W-1:BEAT_BITS] + BLK_W'(1);
                end
            end
        end
    end

    assign Iaddr = cnt_q[4:0];
    assign iacnt = cnt_q[CNT_W-1:BEAT_BITS];
    assign ibcnt = bcnt_q;

    // ---------------- AXI domain: request detection ----------------
    logic start_c;

    s2a_controller_toggle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_toggle_sync (
        .clk     (AXI_clk),
        .rst_n   (AXI_rst_n),
        .tog_in  (req_tog_q),
        .pulse_c (start_c)
    );

    // ---------------- AXI write FSM ----------------
    s2a_state_e        state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              wlast_q, wlast_d;
    logic              bready_q, bready_d;
    logic [4:0]        s2a_addr_q, s2a_addr_d;
    logic              direct_c;
    logic              consumed_c;

    always_ff @(posedge AXI_clk) begin
        if (!AXI_rst_n) begin
            state_q     <= S2A_IDLE;
            awaddr_q    <= '0;
            pend_addr_q <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            s2a_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            pend_addr_q <= pend_addr_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            s2a_addr_q  <= s2a_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        pend_addr_d = pend_addr_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        s2a_addr_d  = s2a_addr_q;
        consumed_c  = 1'b0;
        direct_c    = start_c && (state_q == S2A_IDLE) && !pending_q;

        unique case (state_q)
            S2A_IDLE: begin
                if (pending_q) begin
                    awaddr_d   = pend_addr_q;
                    pending_d  = 1'b0;
                    consumed_c = 1'b1;
                    state_d    = S2A_ADDR;
                end else if (start_c) begin
                    awaddr_d = awaddr_lat_q;
                    state_d  = S2A_ADDR;
                end
            end
            S2A_ADDR: begin
                if (awvalid_q && AXI_awready) begin
                    s2a_addr_d = {awaddr_q[BLK_SHIFT], BEAT_BITS'(0)};
                    state_d    = S2A_DATA;
                end
            end
            S2A_DATA: begin
                if (wvalid_q && AXI_wready) begin
                    s2a_addr_d[BEAT_BITS-1:0] = s2a_addr_q[BEAT_BITS-1:0] + BEAT_BITS'(1);
                    if (wlast_q) begin
                        state_d = S2A_RESP;
                    end
                end
            end
            S2A_RESP: begin
                if (bready_q && AXI_bvalid) begin
                    if (pending_q) begin
                        awaddr_d   = pend_addr_q;
                        pending_d  = 1'b0;
                        consumed_c = 1'b1;
                        state_d    = S2A_ADDR;
                    end else begin
                        state_d = S2A_IDLE;
                    end
                end
            end
        endcase

        // A request that cannot launch directly parks in the single pending slot; newest wins
        if (start_c && !direct_c) begin
            pend_addr_d = awaddr_lat_q;
            pending_d   = 1'b1;
            if (pending_q && !consumed_c) begin
                overrun_d = 1'b1;
            end
        end

        awvalid_d = (state_d == S2A_ADDR);
        wvalid_d  = (state_d == S2A_DATA);
        bready_d  = (state_d == S2A_RESP);
        wlast_d   = wvalid_d && (s2a_addr_d[BEAT_BITS-1:0] == BEAT_BITS'(BURST_LEN - 1));
    end

    assign AXI_awaddr  = awaddr_q;
    assign AXI_awvalid = awvalid_q;
    assign AXI_wvalid  = wvalid_q;
    assign AXI_wlast   = wlast_q;
    assign AXI_bready  = bready_q;
    assign s2a_addr    = s2a_addr_q;
    assign s2a_en      = wvalid_q & AXI_wready;
    assign overrun     = overrun_q;

`ifdef S2A_BRESP_CHECK_EN
    logic [15:0] bresp_err_q;

    // Saturating count of non-OKAY write responses
    always_ff @(posedge AXI_clk) begin
        if (!AXI_rst_n) begin
            bresp_err_q <= '0;
        end else if (bready_q && AXI_bvalid && (AXI_bresp != 2'b00) && (bresp_err_q != 16'hFFFF)) begin
            bresp_err_q <= bresp_err_q + 16'd1;
        end
    end

    assign bresp_err_cnt = bresp_err_q;
`endif

endmodule

// File: tb/tb_s2a_controller.sv
// Directed self-checking bench for s2a_controller with a simple AXI write slave and burst monitor.
module tb_s2a_controller;

    int sclk_half = 5;
    int axi_half  = 5;

    logic Sclk    = 1'b0;
    logic AXI_clk = 1'b0;
    always #(sclk_half) Sclk = ~Sclk;
    always #(axi_half) AXI_clk = ~AXI_clk;

    logic        rst = 1'b1;
    logic        sync = 1'b0;
    logic        Ien = 1'b0;
    logic [4:0]  Iaddr;
    logic [31:0] ibase = 32'h1000_0000;
    logic [23:6] isize = 18'd4;
    logic [23:6] iacnt;
    logic [31:0] ibcnt;
    logic        AXI_rst_n = 1'b0;
    logic [31:0] AXI_awaddr;
    logic        AXI_awvalid;
    logic        AXI_awready = 1'b0;
    logic        AXI_wvalid;
    logic        AXI_wready = 1'b0;
    logic        AXI_wlast;
    logic        AXI_bvalid = 1'b0;
    logic        AXI_bready;
    logic [4:0]  s2a_addr;
    logic        s2a_en;
    logic        overrun;
`ifdef S2A_BRESP_CHECK_EN
    logic [1:0]  AXI_bresp = 2'b00;
    logic [15:0] bresp_err_cnt;
`endif

    s2a_controller dut (
        .Sclk        (Sclk),
        .rst         (rst),
        .sync        (sync),
        .Ien         (Ien),
        .Iaddr       (Iaddr),
        .ibase       (ibase),
        .isize       (isize),
        .iacnt       (iacnt),
        .ibcnt       (ibcnt),
        .AXI_clk     (AXI_clk),
        .AXI_rst_n   (AXI_rst_n),
        .AXI_awaddr  (AXI_awaddr),
        .AXI_awvalid (AXI_awvalid),
        .AXI_awready (AXI_awready),
        .AXI_wvalid  (AXI_wvalid),
        .AXI_wready  (AXI_wready),
        .AXI_wlast   (AXI_wlast),
        .AXI_bvalid  (AXI_bvalid),
        .AXI_bready  (AXI_bready),
        .s2a_addr    (s2a_addr),
        .s2a_en      (s2a_en),
        .overrun     (overrun)
`ifdef S2A_BRESP_CHECK_EN
        ,
        .AXI_bresp     (AXI_bresp),
        .bresp_err_cnt (bresp_err_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // AXI slave knobs
    logic       aw_en     = 1'b1;
    logic       w_rand    = 1'b0;
    logic [1:0] bresp_val = 2'b00;
    int         n_forced  = 0;

    always @(posedge AXI_clk) begin
        #1;
        AXI_awready = aw_en;
        if (w_rand && AXI_wvalid && AXI_wlast && n_forced == 0) begin
            AXI_wready = 1'b0;
            n_forced++;
        end else if (w_rand) begin
            AXI_wready = 1'($urandom_range(0, 1));
        end else begin
            AXI_wready = 1'b1;
        end
        AXI_bvalid = AXI_bready;
`ifdef S2A_BRESP_CHECK_EN
        AXI_bresp = bresp_val;
`endif
    end

    // Burst monitor
    logic [31:0] aw_addr [0:63];
    int          b_beats [0:63];
    logic [4:0]  b_first [0:63];
    logic [4:0]  b_last  [0:63];
    logic        b_ok    [0:63];
    int          n_aw = 0, n_burst = 0, cur_beats = 0, n_last_stall = 0;
    logic [4:0]  cur_first = 5'd0;
    logic [4:0]  hold_addr = 5'd0;
    logic        cur_ok = 1'b1;
    logic        hold_pend = 1'b0;

    always @(negedge AXI_clk) begin
        if (AXI_awvalid && AXI_awready) begin
            if (n_aw < 64) aw_addr[n_aw] = AXI_awaddr;
            n_aw++;
        end
        if (hold_pend && (AXI_wvalid !== 1'b1 || s2a_addr !== hold_addr)) cur_ok = 1'b0;
        hold_pend = AXI_wvalid && !AXI_wready;
        hold_addr = s2a_addr;
        if (AXI_wvalid && AXI_wlast && !AXI_wready) n_last_stall++;
        if (s2a_en) begin
            if (cur_beats == 0) cur_first = s2a_addr;
            if (s2a_addr !== 5'(int'(cur_first) + cur_beats)) cur_ok = 1'b0;
            if (AXI_wlast !== (cur_beats == 15)) cur_ok = 1'b0;
            cur_beats++;
            if (AXI_wlast || cur_beats > 40) begin
                if (n_burst < 64) begin
                    b_beats[n_burst] = cur_beats;
                    b_first[n_burst] = cur_first;
                    b_last[n_burst]  = s2a_addr;
                    b_ok[n_burst]    = cur_ok;
                end
                n_burst++;
                cur_beats = 0;
                cur_ok    = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n);
        @(posedge Sclk);
        #1;
        for (int i = 0; i < n; i++) begin
            Ien = 1'b1;
            @(posedge Sclk);
            #1;
        end
        Ien = 1'b0;
    endtask

    task automatic wait_bursts(input string tag, input int target);
        int cyc;
        cyc = 0;
        while (n_burst < target && cyc < 5000) begin
            @(posedge AXI_clk);
            cyc++;
        end
        repeat (6) @(posedge AXI_clk);
        #1;
        check({tag, "_bursts_done"}, 32'(n_burst >= target), 32'd1);
    endtask

    task automatic check_burst(input string tag, input int idx, input logic [31:0] exp_addr,
                               input logic [4:0] exp_first);
        check({tag, "_awaddr"}, aw_addr[idx], exp_addr);
        check({tag, "_beats"}, 32'(b_beats[idx]), 32'd16);
        check({tag, "_first"}, 32'(b_first[idx]), 32'(exp_first));
        check({tag, "_last"}, 32'(b_last[idx]), 32'(5'(exp_first + 5'd15)));
        check({tag, "_seq_ok"}, 32'(b_ok[idx]), 32'd1);
    endtask

    int nb0;

    initial begin
        // Reset
        repeat (4) @(posedge AXI_clk);
        #1;
        check("rst_Iaddr", 32'(Iaddr), 32'd0);
        check("rst_iacnt", 32'(iacnt), 32'd0);
        check("rst_ibcnt", ibcnt, 32'd0);
        check("rst_awaddr", AXI_awaddr, 32'd0);
        check("rst_awvalid", 32'(AXI_awvalid), 32'd0);
        check("rst_wvalid", 32'(AXI_wvalid), 32'd0);
        check("rst_wlast", 32'(AXI_wlast), 32'd0);
        check("rst_bready", 32'(AXI_bready), 32'd0);
        check("rst_s2a_addr", 32'(s2a_addr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        AXI_rst_n = 1'b1;
        repeat (2) @(posedge Sclk);

        // One half -> one burst at ibase
        push(16);
        check("t1_Iaddr", 32'(Iaddr), 32'd16);
        check("t1_iacnt", 32'(iacnt), 32'd1);
        wait_bursts("t1", 1);
        check_burst("t1_b0", 0, 32'h1000_0000, 5'd0);

        // Fill the rest of the 4-block region; halves alternate
        push(48);
        wait_bursts("t2", 4);
        check_burst("t2_b1", 1, 32'h1000_0040, 5'd16);
        check_burst("t2_b2", 2, 32'h1000_0080, 5'd0);
        check_burst("t2_b3", 3, 32'h1000_00C0, 5'd16);
        check("t2_ibcnt", ibcnt, 32'd1);
        check("t2_iacnt", 32'(iacnt), 32'd0);

        // Address channel stalled: one pending, one overrun, newest pending wins
        aw_en = 1'b0;
        push(48);
        repeat (6) @(posedge AXI_clk);
        #1;
        check("t3_no_aw_while_held", 32'(n_aw), 32'd4);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_iacnt", 32'(iacnt), 32'd3);
        aw_en = 1'b1;
        wait_bursts("t3", 6);
        check_burst("t3_b4", 4, 32'h1000_0000, 5'd0);
        check_burst("t3_b5", 5, 32'h1000_0080, 5'd0);
        repeat (30) @(posedge AXI_clk);
        #1;
        check("t3_no_extra_burst", 32'(n_aw), 32'd6);

        // Random write back-pressure, forced stall on the last beat
        w_rand = 1'b1;
        push(16);
        wait_bursts("t4", 7);
        check_burst("t4_b6", 6, 32'h1000_00C0, 5'd16);
        check("t4_last_beat_stalled", 32'(n_last_stall > 0), 32'd1);
        check("t4_ibcnt", ibcnt, 32'd2);
        check("t4_iacnt", 32'(iacnt), 32'd0);
        w_rand = 1'b0;

        // sync at cnt=0x25
        push(37);
        check("t5_Iaddr", 32'(Iaddr), 32'd5);
        check("t5_iacnt", 32'(iacnt), 32'd2);
        wait_bursts("t5", 9);
        check_burst("t5_b7", 7, 32'h1000_0000, 5'd0);
        check_burst("t5_b8", 8, 32'h1000_0040, 5'd16);
        @(posedge Sclk);
        #1;
        sync = 1'b1;
        @(posedge Sclk);
        #1;
        sync = 1'b0;
        check("t5_sync_Iaddr", 32'(Iaddr), 32'd0);
        check("t5_sync_iacnt", 32'(iacnt), 32'd0);
        check("t5_sync_ibcnt", ibcnt, 32'd0);
        repeat (30) @(posedge Sclk);
        #1;
        check("t5_no_spurious", 32'(n_aw), 32'd9);

`ifdef S2A_BRESP_CHECK_EN
        bresp_val = 2'b10;
        nb0 = n_burst;
        push(32);
        wait_bursts("t5b", nb0 + 2);
        bresp_val = 2'b00;
        check("t5b_bresp_err_cnt", 32'(bresp_err_cnt), 32'd2);
`endif

        // rst mid-burst, Sclk:AXI_clk = 1:3
        sclk_half = 5;
        axi_half  = 15;
        nb0 = n_burst;
        push(32);
        repeat (4) @(posedge AXI_clk);
        @(posedge Sclk);
        #1;
        rst = 1'b1;
        @(posedge Sclk);
        #1;
        check("t6a_rst_Iaddr", 32'(Iaddr), 32'd0);
        check("t6a_rst_iacnt", 32'(iacnt), 32'd0);
        check("t6a_rst_ibcnt", ibcnt, 32'd0);
        rst = 1'b0;
        wait_bursts("t6a", nb0 + 2);
        check("t6a_b0_beats", 32'(b_beats[nb0]), 32'd16);
        check("t6a_b1_beats", 32'(b_beats[nb0 + 1]), 32'd16);
        check("t6a_overrun_kept", 32'(overrun), 32'd1);
        push(16);
        wait_bursts("t6a_post", nb0 + 3);
        check_burst("t6a_post", nb0 + 2, 32'h1000_0000, 5'd0);

        // rst mid-burst, Sclk:AXI_clk = 3:1
        sclk_half = 15;
        axi_half  = 5;
        nb0 = n_burst;
        push(16);
        repeat (2) @(posedge Sclk);
        #1;
        rst = 1'b1;
        @(posedge Sclk);
        #1;
        check("t6b_rst_Iaddr", 32'(Iaddr), 32'd0);
        check("t6b_rst_iacnt", 32'(iacnt), 32'd0);
        check("t6b_rst_ibcnt", ibcnt, 32'd0);
        rst = 1'b0;
        wait_bursts("t6b", nb0 + 1);
        check_burst("t6b_mid", nb0, 32'h1000_0040, 5'd16);
        push(16);
        wait_bursts("t6b_post", nb0 + 2);
        check_burst("t6b_post", nb0 + 1, 32'h1000_0000, 5'd0);

        // isize = 1: every half targets ibase, bcnt counts every half
        sclk_half = 5;
        axi_half  = 5;
        @(posedge Sclk);
        #1;
        sync = 1'b1;
        @(posedge Sclk);
        #1;
        sync = 1'b0;
        isize = 18'd1;
        nb0 = n_burst;
        push(32);
        check("t7_ibcnt", ibcnt, 32'd2);
        check("t7_iacnt", 32'(iacnt), 32'd0);
        wait_bursts("t7", nb0 + 2);
        check_burst("t7_b0", nb0, 32'h1000_0000, 5'd0);
        check_burst("t7_b1", nb0 + 1, 32'h1000_0000, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
